apb_mem_slave: RTL and testbench
================================

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 Parameter AW, 32, address width in bits.
REQ-002 Parameter DW, 32, data width in bits; SHALL be 8, 16, 32 or 64.
REQ-003 Parameter SW, DW/8, byte select width.
REQ-004 Parameter DEPTH, 256, memory size in DW-bit words; range 1..2**(AW-log2(SW)).
REQ-005 Parameter WAIT, 0, wait states inserted in the access phase; range 0..15.
REQ-006 Port clk  input  1  clock; all logic on the rising edge.
REQ-007 Port rst  input  1  reset; asynchronous, active-high.
REQ-008 Port pstrb  input  1  transfer strobe (slave selected).
REQ-009 Port penable  input  1  access phase enable.
REQ-010 Port pwrite  input  1  1=write, 0=read.
REQ-011 Port paddr  input  AW  byte address.
REQ-012 Port psel  input  SW  byte select; the bit set for each written byte lane.
REQ-013 Port pwdata  input  DW  write data.
REQ-014 Port prdata  output  DW  read data, registered.
REQ-015 Port pready  output  1  transfer ready, registered.
REQ-016 Port pslverr  output  1  slave error, registered; meaningful only while pready=1.

Function
REQ-017 The block SHALL implement an FSM with states IDLE and ACCESS.
REQ-018 IDLE: pready=0 and pslverr=0; a setup cycle (pstrb=1, penable=0) SHALL move the FSM to ACCESS on the next edge and clear the wait counter cnt to 0.
REQ-019 On that same edge, pready SHALL be loaded with (WAIT==0).
REQ-020 ACCESS, pready=0: each edge SHALL increment cnt; pready SHALL be set on the edge where cnt+1==WAIT, giving exactly WAIT access cycles with pready=0.
REQ-021 Completion SHALL be the edge with pstrb=1, penable=1 and pready=1; on that edge the FSM SHALL return to IDLE and clear pready and pslverr.
REQ-022 Transfer latency SHALL be 2+WAIT cycles from setup to completion; back-to-back setup SHALL be accepted in the cycle after completion.
REQ-023 Word index SHALL be paddr[AW-1:log2(SW)].
REQ-024 Error condition: index>=DEPTH, OR paddr[log2(SW)-1:0]!=0 (misaligned, only when SW>1).
REQ-025 pslverr SHALL be loaded with the error condition on the edge that sets pready.
REQ-026 Reads: prdata SHALL be loaded on the edge that sets pready, with mem[index], or 0 on error.
REQ-027 Reads: prdata SHALL hold its value until the next read response is loaded.
REQ-028 Writes: on the completion edge, each byte lane b with psel[b]=1 SHALL be written from pwdata; lanes with psel[b]=0 are unchanged.
REQ-029 Writes with an error condition SHALL leave memory unchanged; psel=0 is a legal no-op write without error.
REQ-030 paddr, pwrite, psel and pwdata SHALL be sampled at the setup edge and held internally; changes during ACCESS SHALL be ignored.
REQ-031 penable=1 while in IDLE (no prior setup) SHALL be ignored: FSM stays IDLE, pready=0, no memory access.
REQ-032 pstrb=0 while in ACCESS (master abort) SHALL return the FSM to IDLE on that edge, with pready=0, pslverr=0 and no write.
REQ-033 A read and a write SHALL never occur in the same cycle; the memory is single-port.

Reset
REQ-034 While rst=1, the FSM SHALL be IDLE and cnt=0, pready=0, pslverr=0, prdata=0, asynchronously.
REQ-035 Reset mid-transfer SHALL abort the transfer without any memory write; memory contents SHALL NOT be reset.
REQ-036 The first setup cycle SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-037 WAIT=0, DW=32: write 0xDEADBEEF to 0x10 with psel=0xF, then read 0x10 -> pready high in the first access cycle, prdata=0xDEADBEEF, pslverr=0, 2 cycles per transfer.
REQ-038 WAIT=3: write 0x11223344 to 0x0, then partial write 0xAABBCCDD with psel=0x5, then read 0x0 -> 3 access cycles with pready=0 each time, read data 0x11BB33DD.
REQ-039 DEPTH=256: read 0x400 and misaligned read 0x2 -> pslverr=1 with pready, prdata=0; a write to 0x400 leaves mem[0] unchanged.
REQ-040 Penable pulse without setup, then master abort (pstrb dropped after 1 wait cycle, WAIT=3) -> pready never asserts, no write; the next normal transfer completes correctly.
REQ-041 Assert rst in the second access cycle of a write (WAIT=2) -> outputs zero immediately; a later read of that address returns the old contents.
REQ-042 Back-to-back: 8 consecutive alternating write/read transfers with no idle cycles -> all complete in 2+WAIT cycles each, with data matching.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB-style memory slave with a configurable number of access wait states.
// Single-port word memory with per-byte-lane writes and registered responses.
module apb_mem_slave #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned SW    = DW / 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WAIT  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pstrb,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [SW-1:0] psel,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr
);

    localparam int unsigned OFF = (SW > 1) ? $clog2(SW) : 0;
    localparam int unsigned IW  = AW - OFF;
    localparam int unsigned MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pready_q, pready_d;
    logic          pslverr_q, pslverr_d;
    logic [DW-1:0] prdata_q, prdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] rd_addr_c;
    logic          rd_err_c;
    logic [DW-1:0] rd_data_c;
    logic          mem_we_c;

    // Out of range or not aligned to a full word.
    function automatic logic addr_err(input logic [AW-1:0] a);
        logic [IW-1:0] idx;
        idx = a[AW-1:OFF];
        return (64'(idx) >= 64'(DEPTH)) || ((a & AW'(SW - 1)) != '0);
    endfunction

    function automatic logic [MW-1:0] mem_idx(input logic [IW-1:0] i);
        return MW'(i);
    endfunction

    // During the setup edge the live bus is decoded; afterwards the captured address.
    assign rd_addr_c = (state_q == IDLE) ? paddr : addr_q;
    assign rd_err_c  = addr_err(rd_addr_c);
    assign rd_data_c = rd_err_c ? '0 : mem[mem_idx(rd_addr_c[AW-1:OFF])];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        addr_d    = addr_q;
        write_d   = write_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        mem_we_c  = 1'b0;
        case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                if (pstrb && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    addr_d  = paddr;
                    write_d = pwrite;
                    sel_d   = psel;
                    wdata_d = pwdata;
                    if (WAIT == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = rd_err_c;
                        if (!pwrite) prdata_d = rd_data_c;
                    end
                end
            end
            ACCESS: begin
                if (!pstrb) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (pready_q) begin
                    if (penable) begin
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        mem_we_c  = write_q && !pslverr_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if ((CW+1)'(cnt_q) + (CW+1)'(1) == (CW+1)'(WAIT)) begin
                        pready_d  = 1'b1;
                        pslverr_d = rd_err_c;
                        if (!write_q) prdata_d = rd_data_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            sel_q     <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
        end
    end

    // Memory contents survive reset; only selected byte lanes are updated.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int unsigned b = 0; b < SW; b++) begin
                if (sel_q[b]) mem[mem_idx(addr_q[AW-1:OFF])][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (WAIT 0, 3, 2) driven by a table,
// hand-written corner sequences and random transfers against a word-array model.
module tb_apb_mem_slave;

    localparam int NI = 3;
    localparam int unsigned WT [NI] = '{0, 3, 2};

    logic        clk = 1'b0;
    logic        rst     [NI];
    logic        pstrb   [NI];
    logic        penable [NI];
    logic        pwrite  [NI];
    logic [31:0] paddr   [NI];
    logic [3:0]  psel    [NI];
    logic [31:0] pwdata  [NI];
    logic [31:0] prdata  [NI];
    logic        pready  [NI];
    logic        pslverr [NI];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] mdl     [NI][16];
    logic [31:0] last_rd [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        apb_mem_slave #(
            .AW(32), .DW(32), .SW(4), .DEPTH(256), .WAIT(WT[g])
        ) u_dut (
            .clk(clk), .rst(rst[g]), .pstrb(pstrb[g]), .penable(penable[g]),
            .pwrite(pwrite[g]), .paddr(paddr[g]), .psel(psel[g]), .pwdata(pwdata[g]),
            .prdata(prdata[g]), .pready(pready[g]), .pslverr(pslverr[g])
        );
    end

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t tv [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
    endfunction

    // One full transfer starting right now (setup cycle); returns after the completion edge.
    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int waits);
        pstrb[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = a; psel[k] = s; pwdata[k] = wd;
        @(posedge clk); #1;
        penable[k] = 1'b1;
        pwrite[k]  = 1'($urandom);
        paddr[k]   = $urandom;
        psel[k]    = 4'($urandom);
        pwdata[k]  = $urandom;
        waits = 0;
        while (!pready[k] && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        rd = prdata[k];
        er = pslverr[k];
        @(posedge clk); #1;
        pstrb[k] = 1'b0; penable[k] = 1'b0;
        chk("pready_after_completion", 64'(pready[k]), 64'(0));
    endtask

    task automatic run(input int k, input bit wr, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er,
                       input string nm);
        logic [31:0] rd;
        logic        er;
        int          waits;
        xfer(k, wr, a, s, wd, rd, er, waits);
        chk({nm, "_waits"}, 64'(waits), 64'(WT[k]));
        chk({nm, "_err"}, 64'(er), 64'(exp_er));
        if (wr) chk({nm, "_prdata_hold"}, 64'(rd), 64'(last_rd[k]));
        else begin
            chk({nm, "_rdata"}, 64'(rd), 64'(exp_rd));
            last_rd[k] = exp_rd;
        end
    endtask

    // Expected values come from the word-array model (only words 0..15 are used in range).
    task automatic model_xfer(input int k, input bit wr, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] wd, input string nm);
        logic        er;
        logic [31:0] exp_rd;
        er = ref_err(a);
        exp_rd = (!wr && !er) ? mdl[k][a[5:2]] : 32'h0;
        run(k, wr, a, s, wd, exp_rd, er, nm);
        if (wr && !er) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[k][a[5:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return 32'($urandom_range(0, 15)) << 2;
        else if (r == 8) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        else return 32'($urandom_range(256, 4095)) << 2;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t0;
        tv[0]  = '{0, 1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        tv[1]  = '{0, 1'b0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
        tv[2]  = '{0, 1'b1, 32'h3FC, 4'hF, 32'hA5A50FF0, 32'h0,        1'b0};
        tv[3]  = '{0, 1'b0, 32'h3FC, 4'h0, 32'h0,        32'hA5A50FF0, 1'b0};
        tv[4]  = '{1, 1'b1, 32'h0,   4'hF, 32'h11223344, 32'h0,        1'b0};
        tv[5]  = '{1, 1'b1, 32'h0,   4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
        tv[6]  = '{1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h11BB33DD, 1'b0};
        tv[7]  = '{1, 1'b0, 32'h400, 4'h0, 32'h0,        32'h0,        1'b1};
        tv[8]  = '{1, 1'b0, 32'h2,   4'h0, 32'h0,        32'h0,        1'b1};
        tv[9]  = '{1, 1'b1, 32'h400, 4'hF, 32'h55555555, 32'h0,        1'b1};
        tv[10] = '{1, 1'b1, 32'h1,   4'hF, 32'hFFFFFFFF, 32'h0,        1'b1};
        tv[11] = '{1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h11BB33DD, 1'b0};
        tv[12] = '{2, 1'b1, 32'h4,   4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
        tv[13] = '{2, 1'b1, 32'h4,   4'h0, 32'h0,        32'h0,        1'b0};
        tv[14] = '{2, 1'b0, 32'h4,   4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
        tv[15] = '{2, 1'b1, 32'h4,   4'hA, 32'h12345678, 32'h0,        1'b0};
        tv[16] = '{2, 1'b0, 32'h4,   4'h0, 32'h0,        32'h12FE560D, 1'b0};

        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; pstrb[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0; psel[k] = '0; pwdata[k] = '0; last_rd[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("reset_pready", 64'(pready[k]), 64'(0));
            chk("reset_pslverr", 64'(pslverr[k]), 64'(0));
            chk("reset_prdata", 64'(prdata[k]), 64'(0));
            rst[k] = 1'b0;
        end

        // Table vectors; the first setup lands on the first edge after reset release.
        for (int i = 0; i < 17; i++) begin
            run(tv[i].k, tv[i].wr, tv[i].a, tv[i].s, tv[i].wd, tv[i].rd, tv[i].er,
                $sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        // Stray penable in IDLE, then a master abort after one wait cycle.
        penable[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pstrb[1] = (i >= 2);
            @(posedge clk); #1;
            chk("idle_penable_pready", 64'(pready[1]), 64'(0));
        end
        pstrb[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        pstrb[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h0; psel[1] = 4'hF; pwdata[1] = 32'h99999999;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        chk("abort_pready_before", 64'(pready[1]), 64'(0));
        pstrb[1] = 1'b0; penable[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_pready_after", 64'(pready[1]), 64'(0));
        end
        run(1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, "after_abort");

        // Fill model-tracked words on every instance.
        for (int k = 0; k < NI; k++)
            for (int w = 0; w < 16; w++)
                model_xfer(k, 1'b1, 32'(w) << 2, 4'hF, $urandom | 32'h1, "init");

        // Reset during the second access cycle of a WAIT=2 write.
        model_xfer(2, 1'b0, 32'hC, 4'h0, 32'h0, "pre_reset_read");
        pstrb[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'hC; psel[2] = 4'hF; pwdata[2] = ~mdl[2][3];
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        #1;
        chk("midrst_pready", 64'(pready[2]), 64'(0));
        chk("midrst_pslverr", 64'(pslverr[2]), 64'(0));
        chk("midrst_prdata", 64'(prdata[2]), 64'(0));
        pstrb[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        last_rd[2] = '0;
        model_xfer(2, 1'b0, 32'hC, 4'h0, 32'h0, "post_reset_read");

        // Back-to-back alternating write/read with no idle cycles.
        for (int k = 0; k < 2; k++) begin
            t0 = 32'(cyc);
            for (int i = 0; i < 8; i++) begin
                if (i % 2 == 0)
                    model_xfer(k, 1'b1, 32'(i) << 2, 4'hF, $urandom, "b2b_wr");
                else
                    model_xfer(k, 1'b0, 32'(i - 1) << 2, 4'h0, 32'h0, "b2b_rd");
            end
            chk("b2b_total_cycles", 64'(32'(cyc) - t0), 64'(8 * (2 + WT[k])));
            @(posedge clk); #1;
        end

        // Random traffic against the model.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 60; i++) begin
                model_xfer(k, 1'($urandom), rand_addr(), 4'($urandom), $urandom, "rand");
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
